// File: rtl/mem_load_queue_if.sv
// Bus bundle for mem_load_queue: EX enqueue, SRAM response, WB retire and ID hazard query.
// A transfer happens only on a cycle where valid && ready are both high; flush and data_ok are single-cycle strobes.
interface mem_load_queue_if #(
    parameter int DEST_W = 5,
    parameter int PC_W   = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_mem;
    logic              in_load;
    logic [2:0]        in_op;
    logic [1:0]        in_ldb;
    logic [31:0]       in_rt;
    logic              in_we;
    logic [DEST_W-1:0] in_dest;
    logic [31:0]       in_alu;
    logic [PC_W-1:0]   in_pc;
    logic              data_ok;
    logic [31:0]       rdata;
    logic              out_valid;
    logic              out_ready;
    logic              out_we;
    logic [DEST_W-1:0] out_dest;
    logic [31:0]       out_result;
    logic [PC_W-1:0]   out_pc;
    logic [DEST_W-1:0] hz_src;
    logic              hz_hit;
    logic              hz_load;
    logic [31:0]       hz_data;

    modport slave (
        input  flush, in_valid, in_mem, in_load, in_op, in_ldb, in_rt, in_we, in_dest, in_alu, in_pc,
               data_ok, rdata, out_ready, hz_src,
        output in_ready, out_valid, out_we, out_dest, out_result, out_pc, hz_hit, hz_load, hz_data
    );

    modport master (
        output flush, in_valid, in_mem, in_load, in_op, in_ldb, in_rt, in_we, in_dest, in_alu, in_pc,
               data_ok, rdata, out_ready, hz_src,
        input  in_ready, out_valid, out_we, out_dest, out_result, out_pc, hz_hit, hz_load, hz_data
    );
endinterface

// File: rtl/mem_load_queue.sv
// Multi-entry MEM stage: in-order SRAM response matching, load lane extraction, in-order retire to WB.
// Define MEM_LQ_BYPASS_EN to let a response for the head entry retire in the same cycle it arrives.
module mem_load_queue #(
    parameter int DEPTH  = 4,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_load_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] dbg_count_o,
    output logic [DROP_W-1:0]      dbg_drop_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mem;
        logic              load;
        logic [2:0]        op;
        logic [1:0]        ldb;
        logic [31:0]       rt;
        logic              we;
        logic [DEST_W-1:0] dest;
        logic [31:0]       alu;
        logic [PC_W-1:0]   pc;
        logic [31:0]       rdata;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q;
    logic [DROP_W-1:0] drop_q;

    function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] ldb,
                                            input logic [31:0] d, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (ldb)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = ldb[1] ? d[31:16] : d[15:0];
        case (op)
            3'd1: r = {{24{b[7]}}, b};
            3'd2: r = {24'b0, b};
            3'd3: r = {{16{h[15]}}, h};
            3'd4: r = {16'b0, h};
            3'd5: begin
                case (ldb)
                    2'd0:    r = {d[7:0], rt[23:0]};
                    2'd1:    r = {d[15:0], rt[15:0]};
                    2'd2:    r = {d[23:0], rt[7:0]};
                    default: r = d;
                endcase
            end
            3'd6: begin
                case (ldb)
                    2'd0:    r = d;
                    2'd1:    r = {rt[31:24], d[31:8]};
                    2'd2:    r = {rt[31:16], d[31:16]};
                    default: r = {rt[31:8], d[31:24]};
                endcase
            end
            default: r = d;
        endcase
        return r;
    endfunction

    // Oldest unanswered mem entry is the one the next in-order response belongs to.
    logic [PW-1:0]     scan_idx, rsp_ptr;
    logic              rsp_found;
    logic [DROP_W-1:0] n_out;
    always_comb begin
        scan_idx  = head_q;
        rsp_ptr   = head_q;
        rsp_found = 1'b0;
        n_out     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (ent_q[scan_idx].valid && ent_q[scan_idx].mem && !ent_q[scan_idx].done) begin
                n_out = n_out + DROP_W'(1);
                if (!rsp_found) begin
                    rsp_found = 1'b1;
                    rsp_ptr   = scan_idx;
                end
            end
        end
    end

    entry_t      head;
    logic        rsp_hit, byp, enq, deq;
    logic [31:0] head_rdata;

    assign head    = ent_q[head_q];
    assign rsp_hit = bus.data_ok && (drop_q == '0) && rsp_found;
`ifdef MEM_LQ_BYPASS_EN
    assign byp = rsp_hit && (rsp_ptr == head_q);
`else
    assign byp = 1'b0;
`endif
    assign head_rdata     = byp ? bus.rdata : head.rdata;
    assign bus.out_valid  = head.valid && (head.done || byp);
    assign bus.in_ready   = (count_q != CW'(DEPTH));
    assign bus.out_we     = bus.out_valid && head.we;
    assign bus.out_dest   = bus.out_valid ? head.dest : '0;
    assign bus.out_pc     = bus.out_valid ? head.pc : '0;
    assign bus.out_result = !bus.out_valid ? 32'h0 :
                            head.load ? extract(head.op, head.ldb, head_rdata, head.rt) : head.alu;
    assign enq            = bus.in_valid && bus.in_ready;
    assign deq            = bus.out_valid && bus.out_ready;
    assign dbg_count_o    = count_q;
    assign dbg_drop_o     = drop_q;

    // Scan oldest to youngest so the last match wins.
    logic [PW-1:0] hz_idx, hz_sel;
    logic          hz_hit, hz_load;
    logic [31:0]   hz_data;
    always_comb begin
        hz_idx  = head_q;
        hz_sel  = head_q;
        hz_hit  = 1'b0;
        hz_load = 1'b0;
        hz_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hz_idx = head_q + PW'(i);
            if (ent_q[hz_idx].valid && ent_q[hz_idx].we && ent_q[hz_idx].dest == bus.hz_src &&
                bus.hz_src != '0) begin
                hz_hit = 1'b1;
                hz_sel = hz_idx;
            end
        end
        if (hz_hit) begin
            hz_load = ent_q[hz_sel].load && !ent_q[hz_sel].done;
            hz_data = ent_q[hz_sel].load ?
                      extract(ent_q[hz_sel].op, ent_q[hz_sel].ldb, ent_q[hz_sel].rdata, ent_q[hz_sel].rt) :
                      ent_q[hz_sel].alu;
        end
    end
    assign bus.hz_hit  = hz_hit;
    assign bus.hz_load = hz_load;
    assign bus.hz_data = hz_data;

    entry_t new_ent;
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.done  = !bus.in_mem;
        new_ent.mem   = bus.in_mem;
        new_ent.load  = bus.in_load;
        new_ent.op    = bus.in_op;
        new_ent.ldb   = bus.in_ldb;
        new_ent.rt    = bus.in_rt;
        new_ent.we    = bus.in_we;
        new_ent.dest  = bus.in_dest;
        new_ent.alu   = bus.in_alu;
        new_ent.pc    = bus.in_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (bus.flush) begin
            // Every cancelled request still owes one response; a response arriving now pays one off.
            for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
            head_q  <= tail_q;
            count_q <= '0;
            drop_q  <= drop_q + n_out - DROP_W'(bus.data_ok && (drop_q != '0 || n_out != '0));
        end else begin
            if (bus.data_ok && drop_q != '0) drop_q <= drop_q - DROP_W'(1);
            if (rsp_hit && !(byp && bus.out_ready)) begin
                ent_q[rsp_ptr].rdata <= bus.rdata;
                ent_q[rsp_ptr].done  <= 1'b1;
            end
            if (deq) begin
                ent_q[head_q].valid <= 1'b0;
                head_q              <= head_q + PW'(1);
            end
            if (enq) begin
                ent_q[tail_q] <= new_ent;
                tail_q        <= tail_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: doc/mem_load_queue.md
Name: mem_load_queue

Overview:
- Parametrised successor to the single-entry MEM stage of the 5-stage MIPS pipeline.
- Holds up to DEPTH in-flight EX->WB instructions, so several data-SRAM requests can be outstanding.
- Matches in-order data_ok responses to entries, performs LB/LBU/LH/LHU/LWL/LWR/LW lane extraction, and retires results in order to WB.
- On flush (exception/ERET), discards the late responses of cancelled requests.

Parameters:
DEPTH, 4, max entries held (power of 2, >=2)
DEST_W, 5, register destination width
PC_W, 32, PC/result width (data fixed at 32)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  WS exception or ERET; cancels all entries
in_valid  in  1  EX offers an instruction
in_ready  out  1  queue accepts (count < DEPTH)
in_mem  in  1  instruction issued a data-SRAM request (expects one data_ok)
in_load  in  1  result taken from memory
in_op  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR
in_ldb  in  2  address[1:0]
in_rt  in  32  rt value for LWL/LWR merge
in_we  in  1  GPR write enable
in_dest  in  DEST_W  destination register
in_alu  in  32  ALU result
in_pc  in  PC_W  instruction PC
data_ok  in  1  one SRAM response, in request order
rdata  in  32  response data
out_valid  out  1  head complete
out_ready  in  1  WB allowin
out_we, out_dest, out_result, out_pc  out  1/DEST_W/32/PC_W  head fields
hz_src  in  DEST_W  ID source register query
hz_hit  out  1  valid entry with we && dest==hz_src && hz_src!=0
hz_load  out  1  youngest matching entry is a load not yet answered (ID must stall)
hz_data  out  32  final result of youngest matching entry, valid when hz_hit && !hz_load

Behaviour:
- Reset: all entries invalid, count=0, drop=0, rsp pointer=head.
- Reset outputs: in_ready=1, out_valid=0, hz_hit=0, hz_load=0, out_*/hz_data=0.
- Circular buffer with head, tail and rsp pointers of clog2(DEPTH) bits, wrapping modulo DEPTH. Count has clog2(DEPTH)+1 bits.
- Enqueue on in_valid&&in_ready. A new entry is done=!in_mem.
- Dequeue on out_valid&&out_ready. Both may occur in the same cycle.
- A full queue does not accept even when dequeuing that cycle.
- rsp advances to the next entry with mem=1.
- On data_ok with drop==0:
  - rdata is stored into the rsp entry and that entry is marked done.
  - rsp advances.
  - data_ok with no outstanding entry is an error; the bench checks that it never occurs.
- out_valid = head valid && head done.
- Extraction is combinational from stored rdata, ldb, op and rt:
  - LB/LBU: byte selected by ldb, sign- or zero-extended.
  - LH/LHU: halfword selected by ldb[1], sign- or zero-extended.
  - LWL ldb=k: rdata[8k+7:0] concatenated with rt[23-8k:0]; k=3 gives the full word.
  - LWR ldb=k: rt[31:32-8k] concatenated with rdata[31:8k].
- out_result = in_load ? extracted : alu.
- Latency: a response is registered; out_valid rises the cycle after data_ok. A non-mem entry is visible the cycle after enqueue.
- Flush (highest priority):
  - Invalidate all entries; count=0; in_valid that cycle is ignored.
  - drop <= drop + (outstanding mem entries) - (data_ok ? 1 : 0).
- While drop>0, each data_ok decrements drop and its data is discarded. Newly enqueued mem entries receive responses only after drop reaches 0.
- Hazard lookup: scans from tail-1 back to head and uses the youngest match.

Optional Feature:
- MEM_LQ_BYPASS_EN defined:
  - When data_ok answers the head entry (drop==0), out_valid=1 in the same cycle.
  - out_result is extracted directly from rdata.
  - If out_ready, the entry retires without being stored.
- Undefined: the one-cycle registered path only.

Test Plan:
- LB ldb=2, rdata=0x12_85_34_56, mem entry, data_ok 3 cycles later -> out_result=0xFFFFFF85 one cycle after data_ok (same cycle with bypass).
- Enqueue 4 mem loads back-to-back (pc 0x100..0x10C) -> in_ready=0 after the 4th; responses 0xA,0xB,0xC,0xD retire in order with matching pc.
- LWL ldb=1, rdata=0xAABBCCDD, rt=0x11223344 -> 0xCCDD3344. LWR ldb=1, same operands -> 0x11AABBCC.
- 3 outstanding loads, flush coincident with data_ok -> drop=2; next 2 data_ok discarded; a new load then gets the 3rd data_ok.
- Two entries with dest=5: older ALU result 0x7, younger load unanswered; hz_src=5 -> hz_hit=1, hz_load=1. After its data_ok: hz_load=0, hz_data = load value.
- Reset asserted with 2 pending entries -> next cycle out_valid=0, in_ready=1, drop=0.
